stoplight_fpga_top: RTL and testbench

Top-level FPGA block for the stoplight example: a two-direction (north/south, east/west) traffic-light controller with a pedestrian-request button, walk lamp, and a seven-segment countdown of the current phase. It sits directly under the board pins. A parameterised prescaler derives a phase tick from the system clock, so simulation can run with a short tick.

---
 rtl/stoplight_pkg.sv | 50 +++++
 rtl/stoplight_tick_gen.sv | 31 +++
 rtl/stoplight_fpga_top.sv | 116 +++++++++++
 tb/tb_stoplight_fpga_top.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stoplight_pkg.sv
// Shared types, lamp encodings, default timings and the seven-segment decode
// for the stoplight controller.
package stoplight_pkg;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        AR1,
        WALK1,
        EW_G,
        EW_Y,
        AR2,
        WALK2
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int DEF_TICK_DIV  = 100_000_000;
    localparam int DEF_G_TIME    = 8;
    localparam int DEF_Y_TIME    = 3;
    localparam int DEF_WALK_TIME = 4;

    // Active-high segments ordered {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] seg;
        seg = 8'h00;
        case (value)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stoplight_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clock cycles; the first
// tick arrives TICK_DIV cycles after reset release.
module stoplight_tick_gen
    import stoplight_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = (count_q == CW'(TICK_DIV - 1));
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stoplight_fpga_top.sv
// Two-direction traffic light with pedestrian crossing and a seven-segment
// countdown of the remaining ticks in the current phase.
module stoplight_fpga_top
    import stoplight_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int G_TIME    = DEF_G_TIME,
    parameter int Y_TIME    = DEF_Y_TIME,
    parameter int WALK_TIME = DEF_WALK_TIME
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [3:0] countdown,
    output logic [7:0] ss0
);

    logic   tick;
    logic   sync1_q, sync1_d;
    logic   sync2_q, sync2_d;
    logic   ped_prev_q, ped_prev_d;
    logic   ped_pending_q, ped_pending_d;
    logic   ped_rise;
    logic   enter_walk;
    state_t state_q, state_d;
    logic [3:0] count_q, count_d;

    stoplight_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .nrst(nrst),
        .tick(tick)
    );

    function automatic logic [3:0] load_value(input state_t s);
        logic [3:0] v;
        v = 4'd0;
        case (s)
            NS_G, EW_G:   v = 4'(G_TIME - 1);
            NS_Y, EW_Y:   v = 4'(Y_TIME - 1);
            WALK1, WALK2: v = 4'(WALK_TIME - 1);
            default:      v = 4'd0;
        endcase
        return v;
    endfunction

    // A crossing after a yellow becomes a walk phase when a request is waiting;
    // a pending request pulls a running green down to its last tick.
    always_comb begin
        sync1_d    = ped_req;
        sync2_d    = sync1_q;
        ped_prev_d = sync2_q;
        ped_rise   = sync2_q & ~ped_prev_q;
        state_d    = state_q;
        count_d    = count_q;
        enter_walk = 1'b0;
        if (tick) begin
            if (count_q == 4'd0) begin
                case (state_q)
                    NS_G:        state_d = NS_Y;
                    NS_Y:        state_d = ped_pending_q ? WALK1 : AR1;
                    AR1, WALK1:  state_d = EW_G;
                    EW_G:        state_d = EW_Y;
                    EW_Y:        state_d = ped_pending_q ? WALK2 : AR2;
                    default:     state_d = NS_G;
                endcase
                count_d    = load_value(state_d);
                enter_walk = (state_d == WALK1) || (state_d == WALK2);
            end else begin
                count_d = count_q - 4'd1;
            end
        end else if ((state_q == NS_G || state_q == EW_G) && ped_pending_q && count_q > 4'd1) begin
            count_d = 4'd1;
        end
        ped_pending_d = ped_rise | (ped_pending_q & ~enter_walk);
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            ped_prev_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            state_q       <= NS_G;
            count_q       <= 4'(G_TIME - 1);
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            ped_prev_q    <= ped_prev_d;
            ped_pending_q <= ped_pending_d;
            state_q       <= state_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        ns_light  = RED;
        ew_light  = RED;
        walk      = 1'b0;
        countdown = count_q;
        ss0       = hex_to_seg(count_q);
        case (state_q)
            NS_G:         ns_light = GRN;
            NS_Y:         ns_light = YEL;
            EW_G:         ew_light = GRN;
            EW_Y:         ew_light = YEL;
            WALK1, WALK2: walk     = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: tb/tb_stoplight_fpga_top.sv
// Self-checking bench for stoplight_fpga_top with a short tick, comparing the
// DUT each cycle against a phase-ring model of the light sequence.
module tb_stoplight_fpga_top;

    localparam int TICK_DIV  = 4;
    localparam int G_TIME    = 8;
    localparam int Y_TIME    = 3;
    localparam int WALK_TIME = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [3:0] countdown;
    logic [7:0] ss0;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: ring of six phases (0 NS green, 1 NS yellow, 2 crossing, 3 EW green,
    // 4 EW yellow, 5 crossing); crossings become walks when a request is waiting.
    int  m_edges;
    int  m_phase;
    bit  m_walk;
    int  m_rem;
    bit  m_pend;
    bit  ped_hist[$];

    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    stoplight_fpga_top #(
        .TICK_DIV (TICK_DIV),
        .G_TIME   (G_TIME),
        .Y_TIME   (Y_TIME),
        .WALK_TIME(WALK_TIME)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .countdown(countdown),
        .ss0      (ss0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hist_at(input int k);
        if (k < 1 || k > ped_hist.size()) return 1'b0;
        return ped_hist[k-1];
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_phase = 0;
        m_walk  = 1'b0;
        m_rem   = G_TIME - 1;
        m_pend  = 1'b0;
        ped_hist.delete();
    endtask

    task automatic model_edge(input bit p);
        bit tick;
        bit rise;
        bit old_pend;
        int next;
        m_edges++;
        ped_hist.push_back(p);
        tick     = (m_edges % TICK_DIV) == 0;
        rise     = hist_at(m_edges - 2) && !hist_at(m_edges - 3);
        old_pend = m_pend;
        if (tick) begin
            if (m_rem == 0) begin
                next   = (m_phase + 1) % 6;
                m_walk = 1'b0;
                if (next == 2 || next == 5) begin
                    m_walk = old_pend;
                    if (old_pend) m_pend = 1'b0;
                    m_rem = old_pend ? WALK_TIME - 1 : 0;
                end else begin
                    m_rem = (next == 0 || next == 3) ? G_TIME - 1 : Y_TIME - 1;
                end
                m_phase = next;
            end else begin
                m_rem--;
            end
        end else if ((m_phase == 0 || m_phase == 3) && old_pend && m_rem > 1) begin
            m_rem = 1;
        end
        if (rise) m_pend = 1'b1;
    endtask

    task automatic check_output();
        check("ns_light", 8'(ns_light), 8'(ns_tab[m_phase]));
        check("ew_light", 8'(ew_light), 8'(ew_tab[m_phase]));
        check("walk", 8'(walk), 8'(m_walk));
        check("countdown", 8'(countdown), 8'(m_rem));
        check("ss0", ss0, seg_tab[m_rem[3:0]]);
        check("ss0_dp", 8'(ss0[7]), 8'd0);
    endtask

    task automatic apply_stimulus(input bit p);
        ped_req = p;
        @(posedge clk);
        model_edge(p);
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset(input int delay);
        #(delay);
        nrst    = 1'b1;
        ped_req = 1'b0;
        model_reset();
        #1;
        check("rst_ns", 8'(ns_light), 8'h01);
        check("rst_ew", 8'(ew_light), 8'h04);
        check("rst_walk", 8'(walk), 8'h00);
        check("rst_countdown", 8'(countdown), 8'h07);
        check("rst_ss0", ss0, 8'h07);
        repeat (2) begin
            @(negedge clk);
            check_output();
        end
        nrst = 1'b0;
    endtask

    initial begin
        // Reset held from time zero, then an undisturbed lap and a bit more.
        do_reset(0);
        for (int c = 1; c <= 100; c++) begin
            apply_stimulus(1'b0);
            if (c == 31) check("fr31_ss0", ss0, 8'h3F);
            if (c == 32) begin
                check("fr32_ns", 8'(ns_light), 8'h02);
                check("fr32_cd", 8'(countdown), 8'd2);
            end
            if (c == 44) begin
                check("fr44_ns", 8'(ns_light), 8'h04);
                check("fr44_ew", 8'(ew_light), 8'h04);
            end
            if (c == 48) begin
                check("fr48_ew", 8'(ew_light), 8'h01);
                check("fr48_cd", 8'(countdown), 8'd7);
            end
            if (c == 96) begin
                check("fr96_ns", 8'(ns_light), 8'h01);
                check("fr96_cd", 8'(countdown), 8'd7);
            end
        end

        // Single press in NS green: shortened green, then a walk, then a full EW green.
        do_reset(1);
        for (int c = 1; c <= 44; c++) begin
            apply_stimulus(c == 2);
            if (c == 5) check("pedA_short_cd", 8'(countdown), 8'd1);
            if (c == 24) begin
                check("pedA_walk", 8'(walk), 8'd1);
                check("pedA_walk_cd", 8'(countdown), 8'd3);
            end
            if (c == 40) begin
                check("pedA_ewg", 8'(ew_light), 8'h01);
                check("pedA_walk_off", 8'(walk), 8'd0);
            end
            if (c == 41) check("pedA_cleared_cd", 8'(countdown), 8'd7);
        end

        // Second press during WALK1 carries over: EW green cut to two ticks, then WALK2.
        do_reset(1);
        for (int c = 1; c <= 64; c++) begin
            apply_stimulus(c == 2 || c == 28);
            if (c == 41) check("pedB_short_cd", 8'(countdown), 8'd1);
            if (c == 48) check("pedB_ewy", 8'(ew_light), 8'h02);
            if (c == 60) check("pedB_walk2", 8'(walk), 8'd1);
        end

        // Asynchronous reset in the middle of EW yellow, then a normal restart.
        do_reset(1);
        for (int c = 1; c <= 86; c++) begin
            apply_stimulus(1'b0);
        end
        check("mid_ewy", 8'(ew_light), 8'h02);
        do_reset(2);
        for (int c = 1; c <= 40; c++) begin
            apply_stimulus(1'b0);
            if (c == 32) check("mid_restart_nsy", 8'(ns_light), 8'h02);
        end

        // Random pedestrian traffic against the model.
        do_reset(1);
        for (int c = 1; c <= 600; c++) begin
            apply_stimulus($urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
